// File: rtl/fp_div_seq.sv
// Sequential floating-point divider, restoring radix-2 significand divide plus RNE rounding.
// Latency: MAN_W+5 edges for normal operands, 1 edge for special operands (zero/inf/NaN).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
module fp_div_seq #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 7,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] opA,
    input  logic [W-1:0] opB,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic         underflow,
    output logic         overflow,
    output logic         inexact,
    output logic         div_by_zero,
    output logic         invalid
);

    localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
    localparam int SW    = MAN_W + 1;          // significand width with hidden one
    localparam int RW    = MAN_W + 2;          // partial remainder width (< 2*divisor)
    localparam int QW    = MAN_W + 3;          // quotient bits: integer, MAN_W fraction, guard
    localparam int EW    = EXP_W + 2;          // signed working exponent width
    localparam int CNT_W = $clog2(QW);

    localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    state_t state, state_nxt;

    // operand field decode
    logic             sa, sb;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] ma, mb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;

    assign {sa, ea, ma} = opA;
    assign {sb, eb, mb} = opB;
    assign a_zero  = (ea == '0);
    assign b_zero  = (eb == '0);
    assign a_inf   = (&ea) && (ma == '0);
    assign b_inf   = (&eb) && (mb == '0);
    assign a_nan   = (&ea) && (ma != '0);
    assign b_nan   = (&eb) && (mb != '0);
    assign special = a_zero | b_zero | (&ea) | (&eb);

    // working registers
    logic            sign_q;
    logic [EW-1:0]   exp_q;
    logic [RW-1:0]   rem;
    logic [SW-1:0]   dvs;
    logic [QW-1:0]   qbits;
    logic [CNT_W-1:0] cnt;
    logic            last_step;

    assign last_step = (cnt == CNT_W'(QW - 1));

    // special-operand result, resolved in priority order NaN > inf > x/0 > zero
    logic [W-1:0] spec_q;
    logic         spec_inv, spec_dbz;
    always_comb begin
        spec_q   = '0;
        spec_inv = 1'b0;
        spec_dbz = 1'b0;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_q   = QNAN;
            spec_inv = 1'b1;
        end else if (a_inf) begin
            spec_q = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (b_zero) begin
            spec_q   = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            spec_dbz = 1'b1;
        end else begin
            spec_q = {sa ^ sb, {(W-1){1'b0}}};
        end
    end

    // one restoring-division step: compare, conditionally subtract, shift
    logic          rem_ge;
    logic [RW-1:0] rem_sub, rem_nxt;
    always_comb begin
        rem_ge  = (rem >= {1'b0, dvs});
        rem_sub = rem_ge ? (rem - {1'b0, dvs}) : rem;
        rem_nxt = rem_sub << 1;
    end

    // normalise, round to nearest even, then range-check the exponent
    logic             msb, guard, sticky, rnd_up;
    logic [MAN_W-1:0] mant_pre;
    logic [MAN_W:0]   mant_sum;
    logic [EW-1:0]    exp_fin;
    logic             rnd_ovf, rnd_unf;
    logic [W-1:0]     rnd_q;
    logic             rnd_inx;
    always_comb begin
        msb      = qbits[QW-1];
        mant_pre = msb ? qbits[QW-2:2] : qbits[QW-3:1];
        guard    = msb ? qbits[1] : qbits[0];
        sticky   = (rem != '0) | (msb & qbits[0]);
        rnd_up   = guard & (sticky | mant_pre[0]);
        mant_sum = {1'b0, mant_pre} + {{MAN_W{1'b0}}, rnd_up};
        exp_fin  = exp_q - {{(EW-1){1'b0}}, ~msb} + {{(EW-1){1'b0}}, mant_sum[MAN_W]};
        rnd_unf  = exp_fin[EW-1] || (exp_fin == '0);
        rnd_ovf  = !exp_fin[EW-1] && (exp_fin[EW-2:0] >= (EW-1)'((1 << EXP_W) - 1));
        rnd_q    = {sign_q, exp_fin[EXP_W-1:0], mant_sum[MAN_W-1:0]};
        rnd_inx  = guard | sticky;
        if (rnd_ovf) begin
            rnd_q   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            rnd_inx = 1'b1;
        end else if (rnd_unf) begin
            rnd_q   = {sign_q, {(W-1){1'b0}}};
            rnd_inx = 1'b1;
        end
    end

    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = special ? DONE : DIVIDE;
            DIVIDE:  if (last_step) state_nxt = ROUND;
            ROUND:   state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // handshake outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // datapath: capture operands, iterate the divide, register the result
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sign_q      <= 1'b0;
            exp_q       <= '0;
            rem         <= '0;
            dvs         <= '0;
            qbits       <= '0;
            cnt         <= '0;
            quotient    <= '0;
            underflow   <= 1'b0;
            overflow    <= 1'b0;
            inexact     <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        sign_q <= sa ^ sb;
                        exp_q  <= EW'(ea) - EW'(eb) + EW'(BIAS);
                        rem    <= {1'b0, 1'b1, ma};
                        dvs    <= {1'b1, mb};
                        qbits  <= '0;
                        cnt    <= '0;
                        if (special) begin
                            quotient    <= spec_q;
                            invalid     <= spec_inv;
                            div_by_zero <= spec_dbz;
                        end
                    end
                end
                DIVIDE: begin
                    rem   <= rem_nxt;
                    qbits <= {qbits[QW-2:0], rem_ge};
                    cnt   <= cnt + CNT_W'(1);
                end
                ROUND: begin
                    quotient  <= rnd_q;
                    overflow  <= rnd_ovf;
                    underflow <= rnd_unf && !rnd_ovf;
                    inexact   <= rnd_inx;
                end
                DONE: begin
                    if (out_ready) begin
                        quotient    <= '0;
                        underflow   <= 1'b0;
                        overflow    <= 1'b0;
                        inexact     <= 1'b0;
                        div_by_zero <= 1'b0;
                        invalid     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
